// File: rtl/vtx_trace_gen.sv
// -----------------------------------------------------------------------------
// vtx_trace_gen
//
// Passive retirement-trace producer. Watches the coprocessor dispatch, CPR
// write and response interfaces and publishes one record per completed
// instruction on the vtx_* bus. It keeps a shadow copy of the 16 CPRs so that
// every record carries the CPR state at dispatch (pre) and at completion
// (post). It never back-pressures the coprocessor; at most one instruction is
// in flight.
//
// Ports
//   vtx_clk, vtx_resetn        clock, synchronous active-low reset
//   cop_insn_*                 dispatch handshake, encoding, rs1 value
//   cprs_wen/waddr/wdata       CPR write port (mirrored into the shadow file)
//   cop_rsp_*                  completion pulse, result code, GPR writeback
//   vtx_reset                  registered copy of ~vtx_resetn
//   vtx_valid                  one-cycle retirement pulse
//   vtx_instr_*                captured dispatch / response fields
//   _N_vtx_cprs_pre/post       CPR N at dispatch / at completion (N = 0..15)
//   trace_err                  sticky protocol-violation flag
// -----------------------------------------------------------------------------
module vtx_trace_gen (
  input  logic        vtx_clk,
  input  logic        vtx_resetn,
  input  logic        cop_insn_valid,
  input  logic        cop_insn_ready,
  input  logic [31:0] cop_insn_enc,
  input  logic [31:0] cop_insn_rs1,
  input  logic        cprs_wen,
  input  logic [3:0]  cprs_waddr,
  input  logic [31:0] cprs_wdata,
  input  logic        cop_rsp_valid,
  input  logic [2:0]  cop_rsp_result,
  input  logic        cop_rsp_wen,
  input  logic [4:0]  cop_rsp_waddr,
  input  logic [31:0] cop_rsp_wdata,
  output logic        vtx_reset,
  output logic        vtx_valid,
  output logic [31:0] vtx_instr_enc,
  output logic [31:0] vtx_instr_rs1,
  output logic [2:0]  vtx_instr_result,
  output logic        vtx_instr_wen,
  output logic [4:0]  vtx_instr_waddr,
  output logic [31:0] vtx_instr_wdata,
  output logic [31:0] _0_vtx_cprs_pre,
  output logic [31:0] _1_vtx_cprs_pre,
  output logic [31:0] _2_vtx_cprs_pre,
  output logic [31:0] _3_vtx_cprs_pre,
  output logic [31:0] _4_vtx_cprs_pre,
  output logic [31:0] _5_vtx_cprs_pre,
  output logic [31:0] _6_vtx_cprs_pre,
  output logic [31:0] _7_vtx_cprs_pre,
  output logic [31:0] _8_vtx_cprs_pre,
  output logic [31:0] _9_vtx_cprs_pre,
  output logic [31:0] _10_vtx_cprs_pre,
  output logic [31:0] _11_vtx_cprs_pre,
  output logic [31:0] _12_vtx_cprs_pre,
  output logic [31:0] _13_vtx_cprs_pre,
  output logic [31:0] _14_vtx_cprs_pre,
  output logic [31:0] _15_vtx_cprs_pre,
  output logic [31:0] _0_vtx_cprs_post,
  output logic [31:0] _1_vtx_cprs_post,
  output logic [31:0] _2_vtx_cprs_post,
  output logic [31:0] _3_vtx_cprs_post,
  output logic [31:0] _4_vtx_cprs_post,
  output logic [31:0] _5_vtx_cprs_post,
  output logic [31:0] _6_vtx_cprs_post,
  output logic [31:0] _7_vtx_cprs_post,
  output logic [31:0] _8_vtx_cprs_post,
  output logic [31:0] _9_vtx_cprs_post,
  output logic [31:0] _10_vtx_cprs_post,
  output logic [31:0] _11_vtx_cprs_post,
  output logic [31:0] _12_vtx_cprs_post,
  output logic [31:0] _13_vtx_cprs_post,
  output logic [31:0] _14_vtx_cprs_post,
  output logic [31:0] _15_vtx_cprs_post,
  output logic        trace_err
);

  localparam int NCPR = 16;
  localparam int XLEN = 32;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_dispatch;
  logic w_rsp;

  // Shadow CPR file and its view with this cycle's write applied
  logic [XLEN-1:0] r_shadow      [NCPR];
  logic [XLEN-1:0] w_shadow_next [NCPR];

  // Staging for the instruction currently in flight
  logic [XLEN-1:0] r_pend_enc;
  logic [XLEN-1:0] r_pend_rs1;
  logic [XLEN-1:0] r_pend_pre [NCPR];

  // Published record
  logic            r_vtx_reset;
  logic            r_vtx_valid;
  logic            r_trace_err;
  logic [XLEN-1:0] r_out_enc;
  logic [XLEN-1:0] r_out_rs1;
  logic [2:0]      r_out_result;
  logic            r_out_wen;
  logic [4:0]      r_out_waddr;
  logic [XLEN-1:0] r_out_wdata;
  logic [XLEN-1:0] r_out_pre  [NCPR];
  logic [XLEN-1:0] r_out_post [NCPR];

  // FSM control decodes
  logic w_emit;            // publish a record at the next edge
  logic w_emit_from_pend;  // record's dispatch half comes from staging
  logic w_load_pend;       // capture a new dispatch into staging
  logic w_pend_from_next;  // staged pre sees this cycle's CPR write
  logic w_viol;            // protocol violation this cycle

  // Muxed record / staging sources
  logic [XLEN-1:0] w_rec_enc;
  logic [XLEN-1:0] w_rec_rs1;
  logic [XLEN-1:0] w_rec_pre      [NCPR];
  logic [XLEN-1:0] w_pend_pre_src [NCPR];

  assign w_dispatch = cop_insn_valid && cop_insn_ready;
  assign w_rsp      = cop_rsp_valid;

  always_comb begin
    for (int i = 0; i < NCPR; i++) begin
      w_shadow_next[i] = (cprs_wen && (cprs_waddr == 4'(i))) ? cprs_wdata : r_shadow[i];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge vtx_clk) begin
    if (!vtx_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_dispatch && !w_rsp) w_state_next = ST_BUSY;
      ST_BUSY: if (w_rsp && !w_dispatch) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: control outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_emit           = 1'b0;
    w_emit_from_pend = 1'b0;
    w_load_pend      = 1'b0;
    w_pend_from_next = 1'b0;
    w_viol           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Dispatch+response together is a single-cycle instruction.
        w_emit      = w_dispatch && w_rsp;
        w_load_pend = w_dispatch && !w_rsp;
        w_viol      = w_rsp && !w_dispatch;
      end
      ST_BUSY: begin
        w_emit           = w_rsp;
        w_emit_from_pend = w_rsp;
        // A dispatch overlapping the response is the next instruction; its
        // pre state must include the retiring instruction's final CPR write.
        w_load_pend      = w_dispatch && w_rsp;
        w_pend_from_next = 1'b1;
        // A dispatch with nothing retiring would be a second in-flight insn.
        w_viol           = w_dispatch && !w_rsp;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rec_enc = w_emit_from_pend ? r_pend_enc : cop_insn_enc;
    w_rec_rs1 = w_emit_from_pend ? r_pend_rs1 : cop_insn_rs1;
    for (int i = 0; i < NCPR; i++) begin
      w_rec_pre[i]      = w_emit_from_pend ? r_pend_pre[i] : r_shadow[i];
      w_pend_pre_src[i] = w_pend_from_next ? w_shadow_next[i] : r_shadow[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow file, published record and status flags
  // ---------------------------------------------------------------------------
  // NOTE: the shadow file is reset like ordinary registers because its contents
  // are observable through the first record after reset and must read as zero.
  always_ff @(posedge vtx_clk) begin
    if (!vtx_resetn) begin
      r_vtx_reset  <= 1'b1;
      r_vtx_valid  <= 1'b0;
      r_trace_err  <= 1'b0;
      r_out_enc    <= '0;
      r_out_rs1    <= '0;
      r_out_result <= '0;
      r_out_wen    <= 1'b0;
      r_out_waddr  <= '0;
      r_out_wdata  <= '0;
      for (int i = 0; i < NCPR; i++) begin
        r_shadow[i]   <= '0;
        r_out_pre[i]  <= '0;
        r_out_post[i] <= '0;
      end
    end else begin
      r_vtx_reset <= 1'b0;
      r_vtx_valid <= w_emit;
      if (w_viol) r_trace_err <= 1'b1;
      for (int i = 0; i < NCPR; i++) begin
        r_shadow[i] <= w_shadow_next[i];
      end
      if (w_emit) begin
        r_out_enc    <= w_rec_enc;
        r_out_rs1    <= w_rec_rs1;
        r_out_result <= cop_rsp_result;
        r_out_wen    <= cop_rsp_wen;
        r_out_waddr  <= cop_rsp_waddr;
        r_out_wdata  <= cop_rsp_wdata;
        for (int i = 0; i < NCPR; i++) begin
          r_out_pre[i]  <= w_rec_pre[i];
          r_out_post[i] <= w_shadow_next[i];
        end
      end
    end
  end

  // Staging is only read after it has been loaded by a dispatch, so it carries
  // no reset.
  always_ff @(posedge vtx_clk) begin
    if (w_load_pend) begin
      r_pend_enc <= cop_insn_enc;
      r_pend_rs1 <= cop_insn_rs1;
      for (int i = 0; i < NCPR; i++) begin
        r_pend_pre[i] <= w_pend_pre_src[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign vtx_reset        = r_vtx_reset;
  assign vtx_valid        = r_vtx_valid;
  assign trace_err        = r_trace_err;
  assign vtx_instr_enc    = r_out_enc;
  assign vtx_instr_rs1    = r_out_rs1;
  assign vtx_instr_result = r_out_result;
  assign vtx_instr_wen    = r_out_wen;
  assign vtx_instr_waddr  = r_out_waddr;
  assign vtx_instr_wdata  = r_out_wdata;

  assign _0_vtx_cprs_pre   = r_out_pre[0];
  assign _1_vtx_cprs_pre   = r_out_pre[1];
  assign _2_vtx_cprs_pre   = r_out_pre[2];
  assign _3_vtx_cprs_pre   = r_out_pre[3];
  assign _4_vtx_cprs_pre   = r_out_pre[4];
  assign _5_vtx_cprs_pre   = r_out_pre[5];
  assign _6_vtx_cprs_pre   = r_out_pre[6];
  assign _7_vtx_cprs_pre   = r_out_pre[7];
  assign _8_vtx_cprs_pre   = r_out_pre[8];
  assign _9_vtx_cprs_pre   = r_out_pre[9];
  assign _10_vtx_cprs_pre  = r_out_pre[10];
  assign _11_vtx_cprs_pre  = r_out_pre[11];
  assign _12_vtx_cprs_pre  = r_out_pre[12];
  assign _13_vtx_cprs_pre  = r_out_pre[13];
  assign _14_vtx_cprs_pre  = r_out_pre[14];
  assign _15_vtx_cprs_pre  = r_out_pre[15];

  assign _0_vtx_cprs_post  = r_out_post[0];
  assign _1_vtx_cprs_post  = r_out_post[1];
  assign _2_vtx_cprs_post  = r_out_post[2];
  assign _3_vtx_cprs_post  = r_out_post[3];
  assign _4_vtx_cprs_post  = r_out_post[4];
  assign _5_vtx_cprs_post  = r_out_post[5];
  assign _6_vtx_cprs_post  = r_out_post[6];
  assign _7_vtx_cprs_post  = r_out_post[7];
  assign _8_vtx_cprs_post  = r_out_post[8];
  assign _9_vtx_cprs_post  = r_out_post[9];
  assign _10_vtx_cprs_post = r_out_post[10];
  assign _11_vtx_cprs_post = r_out_post[11];
  assign _12_vtx_cprs_post = r_out_post[12];
  assign _13_vtx_cprs_post = r_out_post[13];
  assign _14_vtx_cprs_post = r_out_post[14];
  assign _15_vtx_cprs_post = r_out_post[15];

endmodule

// File: tb/tb_vtx_trace_gen.sv
// -----------------------------------------------------------------------------
// tb_vtx_trace_gen
//
// Directed bench for vtx_trace_gen. A transaction-level model (shadow CPR
// array, in-flight instruction record, expected published record) is advanced
// once per clock from the driven inputs; a compare process checks every DUT
// output against it on each falling edge. Literal checks pin the model at the
// key points of each scenario.
// -----------------------------------------------------------------------------
module tb_vtx_trace_gen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        insn_valid, insn_ready;
  logic [31:0] insn_enc, insn_rs1;
  logic        c_wen;
  logic [3:0]  c_waddr;
  logic [31:0] c_wdata;
  logic        rsp_valid;
  logic [2:0]  rsp_result;
  logic        rsp_wen;
  logic [4:0]  rsp_waddr;
  logic [31:0] rsp_wdata;

  logic        d_vreset, d_valid, d_err;
  logic [31:0] d_enc, d_rs1, d_wdata;
  logic [2:0]  d_result;
  logic        d_wen;
  logic [4:0]  d_waddr;
  logic [15:0][31:0] d_pre, d_post;

  always #5 clk = ~clk;

  vtx_trace_gen dut (
    .vtx_clk(clk), .vtx_resetn(resetn),
    .cop_insn_valid(insn_valid), .cop_insn_ready(insn_ready),
    .cop_insn_enc(insn_enc), .cop_insn_rs1(insn_rs1),
    .cprs_wen(c_wen), .cprs_waddr(c_waddr), .cprs_wdata(c_wdata),
    .cop_rsp_valid(rsp_valid), .cop_rsp_result(rsp_result),
    .cop_rsp_wen(rsp_wen), .cop_rsp_waddr(rsp_waddr), .cop_rsp_wdata(rsp_wdata),
    .vtx_reset(d_vreset), .vtx_valid(d_valid),
    .vtx_instr_enc(d_enc), .vtx_instr_rs1(d_rs1),
    .vtx_instr_result(d_result), .vtx_instr_wen(d_wen),
    .vtx_instr_waddr(d_waddr), .vtx_instr_wdata(d_wdata),
    ._0_vtx_cprs_pre(d_pre[0]),   ._1_vtx_cprs_pre(d_pre[1]),
    ._2_vtx_cprs_pre(d_pre[2]),   ._3_vtx_cprs_pre(d_pre[3]),
    ._4_vtx_cprs_pre(d_pre[4]),   ._5_vtx_cprs_pre(d_pre[5]),
    ._6_vtx_cprs_pre(d_pre[6]),   ._7_vtx_cprs_pre(d_pre[7]),
    ._8_vtx_cprs_pre(d_pre[8]),   ._9_vtx_cprs_pre(d_pre[9]),
    ._10_vtx_cprs_pre(d_pre[10]), ._11_vtx_cprs_pre(d_pre[11]),
    ._12_vtx_cprs_pre(d_pre[12]), ._13_vtx_cprs_pre(d_pre[13]),
    ._14_vtx_cprs_pre(d_pre[14]), ._15_vtx_cprs_pre(d_pre[15]),
    ._0_vtx_cprs_post(d_post[0]),   ._1_vtx_cprs_post(d_post[1]),
    ._2_vtx_cprs_post(d_post[2]),   ._3_vtx_cprs_post(d_post[3]),
    ._4_vtx_cprs_post(d_post[4]),   ._5_vtx_cprs_post(d_post[5]),
    ._6_vtx_cprs_post(d_post[6]),   ._7_vtx_cprs_post(d_post[7]),
    ._8_vtx_cprs_post(d_post[8]),   ._9_vtx_cprs_post(d_post[9]),
    ._10_vtx_cprs_post(d_post[10]), ._11_vtx_cprs_post(d_post[11]),
    ._12_vtx_cprs_post(d_post[12]), ._13_vtx_cprs_post(d_post[13]),
    ._14_vtx_cprs_post(d_post[14]), ._15_vtx_cprs_post(d_post[15]),
    .trace_err(d_err)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0]       enc;
    logic [31:0]       rs1;
    logic [15:0][31:0] pre;
  } insn_t;

  logic [15:0][31:0] m_shadow;
  logic              m_busy;
  insn_t             m_cur;
  logic              e_vreset, e_valid, e_err;
  logic [31:0]       e_enc, e_rs1, e_wdata;
  logic [2:0]        e_result;
  logic              e_wen;
  logic [4:0]        e_waddr;
  logic [15:0][31:0] e_pre, e_post;

  task automatic retire(input insn_t ins, input logic [15:0][31:0] post);
    e_valid  = 1'b1;
    e_enc    = ins.enc;
    e_rs1    = ins.rs1;
    e_pre    = ins.pre;
    e_post   = post;
    e_result = rsp_result;
    e_wen    = rsp_wen;
    e_waddr  = rsp_waddr;
    e_wdata  = rsp_wdata;
  endtask

  // Called right after each rising edge, while the inputs sampled at that edge
  // are still applied.
  task automatic model_step();
    logic              disp;
    logic [15:0][31:0] after;
    insn_t             fresh;
    disp  = insn_valid && insn_ready;
    after = m_shadow;
    if (c_wen) after[c_waddr] = c_wdata;
    e_valid = 1'b0;
    if (!resetn) begin
      m_shadow = '0; m_busy = 1'b0;
      e_vreset = 1'b1; e_err = 1'b0;
      e_enc = '0; e_rs1 = '0; e_result = '0; e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
      e_pre = '0; e_post = '0;
    end else begin
      e_vreset = 1'b0;
      fresh.enc = insn_enc;
      fresh.rs1 = insn_rs1;
      fresh.pre = m_shadow;
      if (rsp_valid) begin
        if (m_busy)    retire(m_cur, after);
        else if (disp) retire(fresh, after);
        else           e_err = 1'b1;
      end
      if (disp) begin
        if (m_busy && rsp_valid) begin
          m_cur     = fresh;
          m_cur.pre = after;
        end else if (!m_busy && !rsp_valid) begin
          m_cur  = fresh;
          m_busy = 1'b1;
        end else if (m_busy) begin
          e_err = 1'b1;
        end
      end else if (rsp_valid && m_busy) begin
        m_busy = 1'b0;
      end
      m_shadow = after;
    end
  endtask

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("vtx_reset", 512'(d_vreset), 512'(e_vreset));
      check("vtx_valid", 512'(d_valid), 512'(e_valid));
      check("trace_err", 512'(d_err), 512'(e_err));
      check("record_fields", 512'({d_enc, d_rs1, d_result, d_wen, d_waddr, d_wdata}),
            512'({e_enc, e_rs1, e_result, e_wen, e_waddr, e_wdata}));
      check("cprs_pre", d_pre, e_pre);
      check("cprs_post", d_post, e_post);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    insn_valid = 1'b0; insn_ready = 1'b1; insn_enc = '0; insn_rs1 = '0;
    c_wen = 1'b0; c_waddr = '0; c_wdata = '0;
    rsp_valid = 1'b0; rsp_result = '0; rsp_wen = 1'b0; rsp_waddr = '0; rsp_wdata = '0;
  endtask

  // Apply current inputs for one edge, update the model, then settle.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_en = 1'b1;
    idle_inputs();
  endtask

  task automatic dispatch(input logic [31:0] enc, input logic [31:0] rs1);
    insn_valid = 1'b1; insn_enc = enc; insn_rs1 = rs1;
  endtask

  task automatic cwrite(input logic [3:0] a, input logic [31:0] d);
    c_wen = 1'b1; c_waddr = a; c_wdata = d;
  endtask

  task automatic respond(input logic [2:0] res, input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd);
    rsp_valid = 1'b1; rsp_result = res; rsp_wen = wen; rsp_waddr = wa; rsp_wdata = wd;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    m_shadow = '0; m_busy = 1'b0; m_cur = '0;
    idle_inputs();

    // Reset held three cycles with CPR writes active
    for (int i = 0; i < 3; i++) begin
      resetn = 1'b0; cwrite(4'd3, 32'hFFFF_FFFF); tick();
    end
    check("lit_reset_vreset", 512'(d_vreset), 512'(1'b1));
    check("lit_reset_post3", 512'(d_post[3]), 512'(0));
    resetn = 1'b1; tick();
    check("lit_vreset_release", 512'(d_vreset), 512'(1'b0));

    // Multi-cycle instruction
    cwrite(4'd3, 32'h11); tick();
    dispatch(32'h0000_1234, 32'hAA); tick();
    check("lit_no_valid_busy", 512'(d_valid), 512'(1'b0));
    cwrite(4'd3, 32'h22); tick();
    respond(3'd0, 1'b0, 5'd0, 32'd0); tick();
    check("lit_mc_valid", 512'(d_valid), 512'(1'b1));
    check("lit_mc_pre3", 512'(d_pre[3]), 512'(32'h11));
    check("lit_mc_post3", 512'(d_post[3]), 512'(32'h22));
    check("lit_mc_enc_rs1", 512'({d_enc, d_rs1}), 512'({32'h1234, 32'hAA}));
    tick();
    check("lit_mc_pulse_once", 512'(d_valid), 512'(1'b0));

    // Valid without ready is not a dispatch
    insn_ready = 1'b0; insn_valid = 1'b1; insn_enc = 32'hBAD; tick();

    // Single-cycle instruction with same-cycle CPR write
    dispatch(32'h5555, 32'h1); respond(3'd2, 1'b0, 5'd0, 32'd0);
    cwrite(4'd5, 32'hDEAD_BEEF); tick();
    check("lit_sc_valid", 512'(d_valid), 512'(1'b1));
    check("lit_sc_pre5", 512'(d_pre[5]), 512'(0));
    check("lit_sc_post5", 512'(d_post[5]), 512'(32'hDEAD_BEEF));

    // Overlap: A retires as B dispatches, A writes c1=7
    dispatch(32'hA, 32'h10); tick();
    cwrite(4'd2, 32'h99); tick();
    respond(3'd1, 1'b0, 5'd0, 32'd0); cwrite(4'd1, 32'd7); dispatch(32'hB, 32'h20); tick();
    check("lit_ov_enc_a", 512'(d_enc), 512'(32'hA));
    cwrite(4'd1, 32'd8); tick();
    respond(3'd0, 1'b1, 5'd10, 32'h55); tick();
    check("lit_ov_enc_b", 512'(d_enc), 512'(32'hB));
    check("lit_ov_pre1", 512'(d_pre[1]), 512'(32'd7));
    check("lit_gpr_wb", 512'({d_wen, d_waddr, d_wdata}), 512'({1'b1, 5'd10, 32'h55}));
    tick(); tick();
    check("lit_gpr_held", 512'({d_valid, d_wen, d_waddr, d_wdata}),
          512'({1'b0, 1'b1, 5'd10, 32'h55}));

    // Back-to-back single-cycle instructions
    for (int i = 0; i < 4; i++) begin
      dispatch(32'h100 + 32'(i), 32'(i)); respond(3'(i), 1'b1, 5'(i), 32'(i * 3));
      cwrite(4'(i + 8), 32'h1000 + 32'(i)); tick();
    end
    check("lit_b2b_last", 512'({d_valid, d_enc, d_post[11]}),
          512'({1'b1, 32'h103, 32'h1003}));

    // Violations: second dispatch while busy, then response in IDLE
    dispatch(32'hC, 32'h0); tick();
    dispatch(32'hD, 32'h0); tick();
    check("lit_viol_disp", 512'(d_err), 512'(1'b1));
    respond(3'd0, 1'b0, 5'd0, 32'd0); tick();
    check("lit_viol_enc", 512'(d_enc), 512'(32'hC));
    respond(3'd4, 1'b0, 5'd0, 32'd0); tick();
    check("lit_viol_rsp_nov", 512'(d_valid), 512'(1'b0));
    tick(); tick();
    check("lit_err_sticky", 512'(d_err), 512'(1'b1));

    // Reset mid-instruction discards it
    dispatch(32'hE, 32'h0); tick();
    resetn = 1'b0; tick();
    check("lit_err_cleared", 512'(d_err), 512'(1'b0));
    resetn = 1'b1; tick();
    respond(3'd0, 1'b0, 5'd0, 32'd0); tick();
    check("lit_discarded", 512'({d_valid, d_err}), 512'({1'b0, 1'b1}));
    tick();

    @(posedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
